// File: rtl/netlist_resp_misr.sv
// netlist_resp_misr: folds one netlist response vector per accepted beat into a
// Galois MISR, then compares the final signature with a golden value.
// Optional build macro MISR_X_MASK_EN adds resp_xmask, which forces masked
// response bits to zero before compaction.
module netlist_resp_misr #(
   parameter int              WIDTH        = 8,
   parameter int              SIG_W        = 16,
   parameter logic [SIG_W-1:0] POLY        = 16'h1021,
   parameter logic [SIG_W-1:0] SEED        = 16'hFFFF,
   parameter int              NUM_PATTERNS = 256,
   parameter int              CNT_W        = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             resp_valid,
   input  logic [WIDTH-1:0] resp_data,
`ifdef MISR_X_MASK_EN
   input  logic [WIDTH-1:0] resp_xmask,
`endif
   input  logic [SIG_W-1:0] golden_sig,
   output logic             resp_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] pat_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   logic               ready_r;
   logic               busy_r;
   logic               done_r;
   logic               pass_r;
   logic [SIG_W-1:0]   sig_r;
   logic [CNT_W-1:0]   cnt_r;

   logic [WIDTH-1:0]   data_s;
   logic               accept_s;
   logic               last_s;
   logic [SIG_W-1:0]   sig_next_s;

   // One MISR step: shift left, apply polynomial feedback on the carry-out, xor in the response.
   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [WIDTH-1:0] data);
      logic [SIG_W-1:0] fb;
      fb = sig[SIG_W-1] ? POLY : {SIG_W{1'b0}};
      return {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(data);
   endfunction

   // Response masking, beat acceptance and next-signature computation.
   always_comb begin
      data_s     = resp_data;
`ifdef MISR_X_MASK_EN
      data_s     = resp_data & ~resp_xmask;
`endif
      accept_s   = resp_valid & ready_r;
      sig_next_s = misr_step(sig_r, data_s);
      if (cnt_r == CNT_W'(NUM_PATTERNS - 1)) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
   end

   // Run-control FSM; ready/busy/done are registered alongside the state so they follow it exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
         sig_r   <= {SIG_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  state_r <= RUN;
                  ready_r <= 1'b1;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  pass_r  <= 1'b0;
                  sig_r   <= SEED;
                  cnt_r   <= {CNT_W{1'b0}};
               end
            end
            RUN: begin
               if (accept_s) begin
                  sig_r <= sig_next_s;
                  cnt_r <= cnt_r + CNT_W'(1);
                  if (last_s) begin
                     state_r <= DONE;
                     ready_r <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     pass_r  <= (sig_next_s == golden_sig);
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               ready_r <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               pass_r  <= 1'b0;
               sig_r   <= {SIG_W{1'b0}};
               cnt_r   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign resp_ready = ready_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign pass       = pass_r;
   assign signature  = sig_r;
   assign pat_count  = cnt_r;

endmodule
